// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, fixed-latency imem requests, small instruction FIFO to decode.
// Optional FETCH_MISALIGN_CHK_EN adds fetch_fault_o and blocks fetch after a misaligned redirect.
module fetch_stage #(
    parameter int                DWIDTH   = 32,
    parameter int                AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000),
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_o,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic [DWIDTH-1:0] imem_rdata_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [AWIDTH-1:0] pc_o,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic              fetch_fault_o,
`endif
    output logic [DWIDTH-1:0] insn_o
);
    localparam int            PTRW    = $clog2(DEPTH);
    localparam int            CNTW    = $clog2(DEPTH) + 1;
    localparam logic [CNTW:0] DEPTH_V = (CNTW+1)'(DEPTH);

    logic [AWIDTH-1:0] pc_q;
    logic [AWIDTH-1:0] req_addr_q;
    logic [AWIDTH-1:0] pc_hold_q;
    logic [DWIDTH-1:0] insn_hold_q;
    logic [AWIDTH-1:0] redir_addr;
    logic [AWIDTH-1:0] pc_mem   [DEPTH];
    logic [DWIDTH-1:0] insn_mem [DEPTH];
    logic [PTRW-1:0]   rd_ptr_q;
    logic [PTRW-1:0]   wr_ptr_q;
    logic [CNTW-1:0]   count_q;
    logic              inflight_q;
    logic              pop;
    logic              push;
    logic              req_inhibit;
    logic [CNTW:0]     occ_after_pop;

    assign redir_addr = redirect_pc_i & ~AWIDTH'(3);

`ifdef FETCH_MISALIGN_CHK_EN
    logic fault_q;
    logic misalign;

    assign misalign      = (redirect_pc_i[1:0] != 2'b00);
    // A redirect decides the fault for itself; otherwise the sticky flag gates fetch.
    assign req_inhibit   = redirect_i ? misalign : fault_q;
    assign fetch_fault_o = fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (redirect_i) begin
            fault_q <= misalign;
        end
    end
`else
    assign req_inhibit = 1'b0;
`endif

    always_comb begin
        valid_o       = ~rst & ~redirect_i & (count_q != '0);
        pop           = valid_o & ready_i;
        push          = ~rst & ~redirect_i & inflight_q;
        occ_after_pop = {1'b0, count_q} + {{CNTW{1'b0}}, inflight_q} - {{CNTW{1'b0}}, pop};
        imem_addr_o   = redirect_i ? redir_addr : pc_q;
        if (rst) begin
            imem_req_o = 1'b0;
        end else if (redirect_i) begin
            imem_req_o = ~req_inhibit;
        end else begin
            imem_req_o = ~req_inhibit & (occ_after_pop < DEPTH_V);
        end
        pc_o   = valid_o ? pc_mem[rd_ptr_q]   : pc_hold_q;
        insn_o = valid_o ? insn_mem[rd_ptr_q] : insn_hold_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= BASEADDR;
            req_addr_q  <= '0;
            inflight_q  <= 1'b0;
            pc_hold_q   <= '0;
            insn_hold_q <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            inflight_q <= imem_req_o;
            if (imem_req_o) begin
                req_addr_q <= imem_addr_o;
                pc_q       <= imem_addr_o + AWIDTH'(4);
            end
            if (valid_o) begin
                pc_hold_q   <= pc_o;
                insn_hold_q <= insn_o;
            end
            if (redirect_i) begin
                count_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTRW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTRW'(1);
                end
                count_q <= count_q + CNTW'(push) - CNTW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= req_addr_q;
            insn_mem[wr_ptr_q] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table plus an in-order scoreboard of expected fetch PCs.
module tb_fetch_stage;
    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;
    localparam int          DEPTH = 2;
`ifdef FETCH_MISALIGN_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] insn_o;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_fault_o;
`endif

    fetch_stage #(.DWIDTH(32), .AWIDTH(32), .BASEADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o),
        .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .ready_i(ready_i),
        .valid_o(valid_o),
        .pc_o(pc_o),
`ifdef FETCH_MISALIGN_CHK_EN
        .fetch_fault_o(fetch_fault_o),
`endif
        .insn_o(insn_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        rs;
        logic        chk;
        logic        exp_v;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
    } vec_t;

    int          tests;
    int          fails;
    logic [31:0] sb_q[$];
    logic [31:0] exp_fetch;
    logic [31:0] last_pc;
    logic [31:0] last_insn;
    logic        m_inflight;
    logic        m_fault;
    logic        pend_v;
    logic [31:0] pend_a;
    logic        cap_valid;
    logic [31:0] cap_pc;
    vec_t        tbl[11];

    function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(input logic rdy, input logic redir, input logic [31:0] rpc, input logic rs);
        vec_t v;
        v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.rs = rs;
        v.chk = 1'b0; v.exp_v = 1'b0; v.exp_req = 1'b0; v.exp_addr = 32'h0; v.exp_pc = 32'h0;
        return v;
    endfunction

    function automatic vec_t mkx(input logic rdy, input logic redir, input logic [31:0] rpc, input logic rs,
                                 input logic exp_v, input logic exp_req, input logic [31:0] exp_addr,
                                 input logic [31:0] exp_pc);
        vec_t v;
        v = mk(rdy, redir, rpc, rs);
        v.chk = 1'b1; v.exp_v = exp_v; v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_pc = exp_pc;
        return v;
    endfunction

    // One clock: drive at posedge+1, memory model and checks at negedge.
    task automatic step(input vec_t v);
        int          buffered;
        logic        exp_v;
        logic        exp_req;
        logic        mis;
        logic [31:0] aligned;
        ready_i       = v.rdy;
        redirect_i    = v.redir;
        redirect_pc_i = v.rpc;
        rst           = v.rs;
        @(negedge clk);
        imem_rdata_i = pend_v ? (pend_a ^ KEY) : 32'hDEAD_BEEF;
        cap_valid    = valid_o;
        cap_pc       = pc_o;
        if (v.chk) begin
            chk1("vec_valid", valid_o, v.exp_v);
            chk1("vec_req", imem_req_o, v.exp_req);
            if (v.exp_req) chk32("vec_addr", imem_addr_o, v.exp_addr);
            if (v.exp_v) chk32("vec_pc", pc_o, v.exp_pc);
        end
`ifdef FETCH_MISALIGN_CHK_EN
        chk1("sb_fault", fetch_fault_o, m_fault);
`endif
        if (v.rs) begin
            chk1("sb_rst_req", imem_req_o, 1'b0);
            chk1("sb_rst_valid", valid_o, 1'b0);
            sb_q.delete();
            exp_fetch  = BASE;
            m_inflight = 1'b0;
            m_fault    = 1'b0;
            last_pc    = 32'h0;
            last_insn  = 32'h0;
        end else if (v.redir) begin
            mis     = CHK_EN && (v.rpc[1:0] != 2'b00);
            aligned = {v.rpc[31:2], 2'b00};
            chk1("sb_redir_valid", valid_o, 1'b0);
            chk32("sb_redir_pc_hold", pc_o, last_pc);
            chk32("sb_redir_insn_hold", insn_o, last_insn);
            sb_q.delete();
            exp_req = !mis;
            chk1("sb_redir_req", imem_req_o, exp_req);
            if (exp_req) begin
                chk32("sb_redir_addr", imem_addr_o, aligned);
                sb_q.push_back(aligned);
                exp_fetch = aligned + 32'd4;
            end
            m_inflight = exp_req;
            m_fault    = mis;
        end else begin
            buffered = sb_q.size() - int'(m_inflight);
            exp_v    = (buffered > 0);
            chk1("sb_valid", valid_o, exp_v);
            if (exp_v) begin
                chk32("sb_pc", pc_o, sb_q[0]);
                chk32("sb_insn", insn_o, sb_q[0] ^ KEY);
                last_pc   = sb_q[0];
                last_insn = sb_q[0] ^ KEY;
                if (v.rdy) void'(sb_q.pop_front());
            end else begin
                chk32("sb_pc_hold", pc_o, last_pc);
                chk32("sb_insn_hold", insn_o, last_insn);
            end
            exp_req = !m_fault && (sb_q.size() < DEPTH);
            chk1("sb_req", imem_req_o, exp_req);
            if (exp_req) begin
                chk32("sb_addr", imem_addr_o, exp_fetch);
                sb_q.push_back(exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
            end
            m_inflight = exp_req;
        end
        pend_v = imem_req_o;
        pend_a = imem_addr_o;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(mk(1'b1, 1'b0, 32'h0, 1'b0));
            seen = cap_valid;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s: valid_o stayed 0 for 20 cycles, expected pc %h", name, exp_pc);
        end else begin
            chk32(name, cap_pc, exp_pc);
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; imem_rdata_i = 32'h0;
        pend_v = 1'b0; pend_a = 32'h0; m_inflight = 1'b0; m_fault = 1'b0;
        exp_fetch = BASE; last_pc = 32'h0; last_insn = 32'h0; cap_valid = 1'b0; cap_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        step(mk(1'b0, 1'b0, 32'h0, 1'b1));
        chk1("rst_valid", valid_o, 1'b0);
        chk32("rst_pc_o", pc_o, 32'h0);
        chk32("rst_insn_o", insn_o, 32'h0);

        // Startup latency, then 6+ cycles of backpressure starting at the first valid, then resume.
        tbl[0]  = mkx(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, BASE,          32'h0);
        tbl[1]  = mkx(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, BASE + 32'h4,  32'h0);
        for (int i = 2; i < 8; i++)
            tbl[i] = mkx(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, BASE);
        tbl[8]  = mkx(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, BASE + 32'h8,  BASE);
        tbl[9]  = mkx(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, BASE + 32'hC,  BASE + 32'h4);
        tbl[10] = mkx(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, BASE + 32'h10, BASE + 32'h8);
        for (int i = 0; i < 11; i++) step(tbl[i]);
        chk32("first_insn", last_insn, 32'hA4A5_0008);

        // Redirect with one buffered entry and one response in flight.
        step(mkx(1'b1, 1'b1, BASE + 32'h100, 1'b0, 1'b0, 1'b1, BASE + 32'h100, 32'h0));
        wait_valid("redir_pc", BASE + 32'h100);

        step(mk(1'b1, 1'b1, BASE + 32'h200, 1'b0));
        step(mkx(1'b1, 1'b1, BASE + 32'h300, 1'b0, 1'b0, 1'b1, BASE + 32'h300, 32'h0));
        wait_valid("b2b_pc", BASE + 32'h300);

        // Fill the FIFO, then a one-cycle reset.
        repeat (3) step(mk(1'b0, 1'b0, 32'h0, 1'b0));
        step(mkx(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0));
        step(mkx(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, BASE, 32'h0));
        wait_valid("rst_restart_pc", BASE);

`ifdef FETCH_MISALIGN_CHK_EN
        step(mkx(1'b1, 1'b1, BASE + 32'h102, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
        for (int i = 0; i < 4; i++) begin
            step(mkx(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
            chk1("fault_sticky", fetch_fault_o, 1'b1);
        end
        step(mkx(1'b1, 1'b1, BASE + 32'h104, 1'b0, 1'b0, 1'b1, BASE + 32'h104, 32'h0));
        chk1("fault_clear", fetch_fault_o, 1'b0);
        wait_valid("fault_restart_pc", BASE + 32'h104);
`else
        step(mkx(1'b1, 1'b1, BASE + 32'h102, 1'b0, 1'b0, 1'b1, BASE + 32'h100, 32'h0));
        wait_valid("misalign_pc", BASE + 32'h100);
`endif

        for (int i = 0; i < 300; i++) begin
            logic        r;
            logic        d;
            logic [31:0] a;
            r = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 15) == 0);
            a = BASE + ($urandom_range(0, 255) << 2);
            step(mk(r, d, a, 1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
